wave_buf_reader: RTL and testbench

WAVE_BUF_READER -- requirements
Module: wave_buf_reader

---
 rtl/wave_buf_reader.sv | 179 +++++++++++++++++
 tb/tb_wave_buf_reader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wave_buf_reader.sv
// wave_buf_reader: turns one bank of waveform samples into trace pixels for a
// VGA scan. It runs a 3-stage pixel pipeline around an external 1-cycle-latency
// sample RAM. A small FSM flips the displayed bank, but only in vertical blanking.
module wave_buf_reader #(
  parameter logic [9:0] WAVE_X0 = 10'd20,
  parameter logic [9:0] WAVE_Y0 = 10'd40,
  parameter int         SAMPLES = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_valid,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       frame_start,
  input  logic       buf_full,
  input  logic [7:0] rd_q,
  output logic [7:0] rd_add,
  output logic       rd_bank,
  output logic       buf_swap,
  output logic       pixel_on,
  output logic       pix_valid_d
);

  // Window bounds are widened to 11 bits so the end column/row cannot overflow.
  localparam logic [10:0] X_LO = {1'b0, WAVE_X0};
  localparam logic [10:0] X_HI = X_LO + 11'(SAMPLES);
  localparam logic [10:0] Y_LO = {1'b0, WAVE_Y0};
  localparam logic [10:0] Y_HI = Y_LO + 11'd256;

  localparam logic [1:0] ST_DISPLAY = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_SWAP    = 2'd2;

  // ---------------- stage 0: combinational window decode ----------------
  logic [10:0] w_x;
  logic [10:0] w_y;
  logic        w_in_win;
  logic        w_first;
  logic [7:0]  w_col;
  logic [7:0]  w_row;

  assign w_x      = {1'b0, pix_x};
  assign w_y      = {1'b0, pix_y};
  assign w_in_win = pix_valid && (w_x >= X_LO) && (w_x < X_HI) &&
                    (w_y >= Y_LO) && (w_y < Y_HI);
  assign w_first  = (pix_x == WAVE_X0);
  assign w_col    = 8'(pix_x - WAVE_X0);
  // Sample value 0 sits at the bottom of the window, so the row index is flipped.
  assign w_row    = ~8'(pix_y - WAVE_Y0);

  // ---------------- pipeline registers ----------------
  logic [7:0] r_rd_add;
  logic [7:0] r_row1;
  logic       r_win1;
  logic       r_first1;
  logic       r_valid1;
  logic [7:0] r_row2;
  logic       r_win2;
  logic       r_first2;
  logic       r_valid2;
  logic [7:0] r_prev;
  logic       r_pixel_on;
  logic       r_pix_valid_d;

  // Stage 1: latch the RAM address (held outside the window) and pixel controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_add <= 8'd0;
      r_row1   <= 8'd0;
      r_win1   <= 1'b0;
      r_first1 <= 1'b0;
      r_valid1 <= 1'b0;
    end else begin
      if (w_in_win) begin
        r_rd_add <= w_col;
      end
      r_row1   <= w_row;
      r_win1   <= w_in_win;
      r_first1 <= w_first;
      r_valid1 <= pix_valid;
    end
  end

  // Stage 2: delay the controls one clock so they line up with rd_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row2   <= 8'd0;
      r_win2   <= 1'b0;
      r_first2 <= 1'b0;
      r_valid2 <= 1'b0;
    end else begin
      r_row2   <= r_row1;
      r_win2   <= r_win1;
      r_first2 <= r_first1;
      r_valid2 <= r_valid1;
    end
  end

  // Stage 3: the trace is the vertical span between the previous and current sample.
  logic [7:0] w_prev;
  logic [7:0] w_lo;
  logic [7:0] w_hi;
  logic       w_hit;

  assign w_prev = r_first2 ? rd_q : r_prev;
  assign w_lo   = (w_prev < rd_q) ? w_prev : rd_q;
  assign w_hi   = (w_prev < rd_q) ? rd_q : w_prev;
  assign w_hit  = r_win2 && r_valid2 && (r_row2 >= w_lo) && (r_row2 <= w_hi);

  // Stage 3 registers plus the previous-column sample for the next in-window pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev        <= 8'd0;
      r_pixel_on    <= 1'b0;
      r_pix_valid_d <= 1'b0;
    end else begin
      if (r_win2) begin
        r_prev <= rd_q;
      end
      r_pixel_on    <= w_hit;
      r_pix_valid_d <= r_valid2;
    end
  end

  // ---------------- bank swap FSM ----------------
  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       r_rd_bank;
  logic       r_buf_swap;

  // Next-state logic: a swap is only taken on frame_start while a full bank waits.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_DISPLAY: begin
        if (buf_full && frame_start) begin
          w_state_next = ST_SWAP;
        end else if (buf_full) begin
          w_state_next = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (!buf_full) begin
          w_state_next = ST_DISPLAY;
        end else if (frame_start) begin
          w_state_next = ST_SWAP;
        end
      end
      ST_SWAP: begin
        w_state_next = ST_DISPLAY;
      end
      default: begin
        w_state_next = ST_DISPLAY;
      end
    endcase
  end

  // State, swap pulse and bank register; the bank flips only on leaving SWAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_DISPLAY;
      r_buf_swap <= 1'b0;
      r_rd_bank  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_buf_swap <= (w_state_next == ST_SWAP);
      if (r_state == ST_SWAP) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  assign rd_add      = r_rd_add;
  assign rd_bank     = r_rd_bank;
  assign buf_swap    = r_buf_swap;
  assign pixel_on    = r_pixel_on;
  assign pix_valid_d = r_pix_valid_d;

endmodule

// File: tb/tb_wave_buf_reader.sv
// Self-checking bench for wave_buf_reader: flat-trace scan, a table of step and
// window-boundary vectors, and hand-written bank-swap / reset sequences.
module tb_wave_buf_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_valid = 1'b0;
  logic [9:0] pix_x = 10'd0;
  logic [9:0] pix_y = 10'd0;
  logic       frame_start = 1'b0;
  logic       buf_full = 1'b0;
  logic [7:0] rd_q = 8'd0;
  logic [7:0] rd_add;
  logic       rd_bank;
  logic       buf_swap;
  logic       pixel_on;
  logic       pix_valid_d;

  int n_checks = 0;
  int n_errors = 0;

  wave_buf_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_start(frame_start),
    .buf_full   (buf_full),
    .rd_q       (rd_q),
    .rd_add     (rd_add),
    .rd_bank    (rd_bank),
    .buf_swap   (buf_swap),
    .pixel_on   (pixel_on),
    .pix_valid_d(pix_valid_d)
  );

  always #5 clk = ~clk;

  // Sample RAM model: registered read, one clock of latency.
  logic [7:0] mem [0:255];
  always @(posedge clk) rd_q <= mem[rd_add];

  typedef struct {
    logic       v;
    logic [9:0] x;
    logic [9:0] y;
    logic       exp_on;
    logic [7:0] exp_add;
  } vec_t;

  typedef struct {
    logic on;
    logic v;
    int   tag;
  } pend_t;

  vec_t  vecs[$];
  pend_t pq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s tag=%0d got=%0h expected=%0h", name, tag, act, exp);
    end
  endtask

  // Drive one pixel, check rd_add one clock later and pixel_on/pix_valid_d three later.
  task automatic apply(input logic v, input logic [9:0] x, input logic [9:0] y,
                       input logic exp_on, input logic [7:0] exp_add, input int tag);
    pend_t p;
    pix_valid = v;
    pix_x     = x;
    pix_y     = y;
    tick();
    check("rd_add", tag, {24'd0, rd_add}, {24'd0, exp_add});
    p.on  = exp_on;
    p.v   = v;
    p.tag = tag;
    pq.push_back(p);
    if (pq.size() == 3) begin
      p = pq.pop_front();
      check("pixel_on", p.tag, {31'd0, pixel_on}, {31'd0, p.on});
      check("pix_valid_d", p.tag, {31'd0, pix_valid_d}, {31'd0, p.v});
    end
  endtask

  task automatic drain(input logic [7:0] hold_add);
    for (int i = 0; i < 3; i++) apply(1'b0, 10'd0, 10'd0, 1'b0, hold_add, -1);
    pq.delete();
  endtask

  function automatic void add_vec(input logic v, input int x, input int y,
                                  input logic on, input int a);
    vec_t t;
    t.v = v; t.x = 10'(x); t.y = 10'(y); t.exp_on = on; t.exp_add = 8'(a);
    vecs.push_back(t);
  endfunction

  // Bank-FSM check of buf_swap and rd_bank after one clock.
  task automatic fsm_step(input string name, input logic full, input logic fs,
                          input logic exp_swap, input logic exp_bank);
    buf_full    = full;
    frame_start = fs;
    tick();
    check({name, ".buf_swap"}, 0, {31'd0, buf_swap}, {31'd0, exp_swap});
    check({name, ".rd_bank"}, 0, {31'd0, rd_bank}, {31'd0, exp_bank});
    $display("fsm %s: full=%0d fs=%0d -> buf_swap=%0d rd_bank=%0d", name, full, fs,
             buf_swap, rd_bank);
  endtask

  initial begin
    int         cols[12];
    logic [7:0] model_add;
    logic       e;

    cols = '{18, 19, 20, 21, 22, 23, 216, 217, 218, 219, 220, 221};

    // ---- reset state ----
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst.rd_add", 0, {24'd0, rd_add}, 32'd0);
    check("rst.rd_bank", 0, {31'd0, rd_bank}, 32'd0);
    check("rst.buf_swap", 0, {31'd0, buf_swap}, 32'd0);
    check("rst.pixel_on", 0, {31'd0, pixel_on}, 32'd0);
    check("rst.pix_valid_d", 0, {31'd0, pix_valid_d}, 32'd0);
    rst_n = 1'b1;
    tick();

    // ---- flat trace: every sample 128 lights only row 128 (pix_y = 167) ----
    for (int i = 0; i < 256; i++) mem[i] = 8'd128;
    model_add = 8'd0;
    for (int y = 38; y <= 297; y++) begin
      for (int c = 0; c < 12; c++) begin
        e = (cols[c] >= 20) && (cols[c] < 220) && (y >= 40) && (y < 296);
        if (e) model_add = 8'(cols[c] - 20);
        apply(1'b1, 10'(cols[c]), 10'(y), (e && (y == 167)), model_add, y * 1000 + cols[c]);
      end
      apply(1'b0, 10'd300, 10'(y), 1'b0, model_add, y * 1000 + 999);
    end
    $display("flat scan done: rows 38..297, %0d checks so far", n_checks);
    drain(model_add);

    // ---- step: sample 50 = 200, all others 10 ----
    for (int i = 0; i < 256; i++) mem[i] = 8'd10;
    mem[50] = 8'd200;
    // row 9 (y=286): nothing lit
    add_vec(1, 20, 286, 0, 0);  add_vec(1, 68, 286, 0, 48);
    add_vec(1, 69, 286, 0, 49); add_vec(1, 70, 286, 0, 50);
    // row 10 (y=285): every column lit
    add_vec(1, 20, 285, 1, 0);  add_vec(1, 68, 285, 1, 48);
    add_vec(1, 69, 285, 1, 49); add_vec(1, 70, 285, 1, 50);
    // row 100 (y=195): only the rising and falling edges
    add_vec(1, 20, 195, 0, 0);  add_vec(1, 68, 195, 0, 48);
    add_vec(1, 69, 195, 0, 49); add_vec(1, 70, 195, 1, 50);
    add_vec(1, 71, 195, 1, 51);
    // row 200 (y=95): top of the step
    add_vec(1, 20, 95, 0, 0);   add_vec(1, 68, 95, 0, 48);
    add_vec(1, 69, 95, 0, 49);  add_vec(1, 70, 95, 1, 50);
    // row 201 (y=94): above the step
    add_vec(1, 20, 94, 0, 0);   add_vec(1, 68, 94, 0, 48);
    add_vec(1, 69, 94, 0, 49);  add_vec(1, 70, 94, 0, 50);
    // window boundaries; col 199 follows col 50 (200) so row 100 is in 10..200
    add_vec(1, 19, 195, 0, 50);
    add_vec(1, 219, 195, 1, 199);
    add_vec(1, 220, 195, 0, 199);
    add_vec(0, 70, 195, 0, 199);
    add_vec(1, 70, 39, 0, 199);
    add_vec(1, 70, 296, 0, 199);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].v, vecs[i].x, vecs[i].y, vecs[i].exp_on, vecs[i].exp_add, i);
      $display("vec %0d: v=%0d x=%0d y=%0d rd_add=%0d exp_add=%0d", i, vecs[i].v,
               vecs[i].x, vecs[i].y, rd_add, vecs[i].exp_add);
    end
    drain(8'd199);

    // ---- bank swap sequences ----
    fsm_step("pend0", 1'b1, 1'b0, 1'b0, 1'b0);
    fsm_step("pend1", 1'b1, 1'b0, 1'b0, 1'b0);
    fsm_step("pend2", 1'b1, 1'b0, 1'b0, 1'b0);
    fsm_step("fs_a", 1'b1, 1'b1, 1'b1, 1'b0);
    fsm_step("post_a", 1'b1, 1'b0, 1'b0, 1'b1);
    fsm_step("pend3", 1'b1, 1'b0, 1'b0, 1'b1);
    fsm_step("fs_b", 1'b1, 1'b1, 1'b1, 1'b1);
    fsm_step("post_b", 1'b0, 1'b0, 1'b0, 1'b0);
    // frame_start without buf_full: the same bank is redisplayed
    fsm_step("idle0", 1'b0, 1'b0, 1'b0, 1'b0);
    fsm_step("fs_nofull", 1'b0, 1'b1, 1'b0, 1'b0);
    fsm_step("idle1", 1'b0, 1'b0, 1'b0, 1'b0);
    // buf_full rising together with frame_start: swap on the very next clock
    fsm_step("fs_sim", 1'b1, 1'b1, 1'b1, 1'b0);
    fsm_step("post_sim", 1'b0, 1'b0, 1'b0, 1'b1);
    // buf_full dropping in PENDING cancels the swap
    fsm_step("pend_drop0", 1'b1, 1'b0, 1'b0, 1'b1);
    fsm_step("pend_drop1", 1'b0, 1'b0, 1'b0, 1'b1);
    fsm_step("fs_dropped", 1'b0, 1'b1, 1'b0, 1'b1);
    fsm_step("idle2", 1'b0, 1'b0, 1'b0, 1'b1);

    // ---- reset in PENDING, held 2 clocks ----
    fsm_step("pend_rst", 1'b1, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst.rd_bank", 0, {31'd0, rd_bank}, 32'd0);
    check("async_rst.buf_swap", 0, {31'd0, buf_swap}, 32'd0);
    buf_full = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    fsm_step("after_rst0", 1'b0, 1'b0, 1'b0, 1'b0);
    fsm_step("after_rst_fs", 1'b0, 1'b1, 1'b0, 1'b0);
    fsm_step("after_rst1", 1'b0, 1'b0, 1'b0, 1'b0);

    // ---- reset in SWAP aborts the toggle ----
    fsm_step("swap_rst", 1'b1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("swap_rst.buf_swap", 0, {31'd0, buf_swap}, 32'd0);
    check("swap_rst.rd_bank", 0, {31'd0, rd_bank}, 32'd0);
    buf_full    = 1'b0;
    frame_start = 1'b0;
    tick();
    rst_n = 1'b1;
    fsm_step("after_swap_rst", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
